// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcode constants, instruction classes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Standard RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_NONE  = 4'd0,
    CLS_R     = 4'd1,
    CLS_I     = 4'd2,
    CLS_L     = 4'd3,
    CLS_S     = 4'd4,
    CLS_B     = 4'd5,
    CLS_JAL   = 4'd6,
    CLS_JALR  = 4'd7,
    CLS_LUI   = 4'd8,
    CLS_AUIPC = 4'd9
  } cls_t;

  // Operand A select
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b10;
  localparam logic [1:0] OPA_ZERO = 2'b11;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // PC source select
  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_JAL  = 2'b01;
  localparam logic [1:0] NPC_BR   = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  // ALU op is {funct7[5], funct3}; only the fixed codes live here
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Trap reasons
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Classes that write a destination register in WB
  function automatic logic cls_writes_rd(input cls_t c);
    return (c == CLS_R) || (c == CLS_I) || (c == CLS_L) || (c == CLS_JAL) ||
           (c == CLS_JALR) || (c == CLS_LUI) || (c == CLS_AUIPC);
  endfunction

endpackage

// File: rtl/rv32_opcode_class.sv
// Combinational RV32I opcode classifier: maps IR[6:0] to an instruction
// class, flagging anything outside the supported set as illegal.
module rv32_opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_t       o_cls,
  output logic       o_illegal
);

  // Opcode lookup; unknown opcodes report CLS_NONE plus illegal
  always_comb begin
    o_cls     = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_R:     o_cls = CLS_R;
      OPC_I:     o_cls = CLS_I;
      OPC_L:     o_cls = CLS_L;
      OPC_S:     o_cls = CLS_S;
      OPC_B:     o_cls = CLS_B;
      OPC_JAL:   o_cls = CLS_JAL;
      OPC_JALR:  o_cls = CLS_JALR;
      OPC_LUI:   o_cls = CLS_LUI;
      OPC_AUIPC: o_cls = CLS_AUIPC;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: IDLE -> DECODE -> EXEC -> [MEM] -> WB,
// with TRAP for illegal opcodes and data-memory timeouts.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        trap_ack,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_req,
  output logic        store,
  output logic        op_b,
  output logic        pc_write,
  output logic        trap,
  output logic [1:0]  op_a,
  output logic [2:0]  imm_sel,
  output logic [1:0]  next_pc,
  output logic [3:0]  alu_op,
  output logic [1:0]  trap_cause
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ir;
  cls_t             r_cls;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;

  cls_t             w_cls;
  logic             w_illegal;
  logic             w_timeout;
  logic             w_dp_valid;
  logic             w_unused_ir;

  // IR bits the control path never looks at (register indices, immediates)
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  rv32_opcode_class u_cls (
    .i_opcode  (r_ir[6:0]),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // This MEM cycle is the last one allowed; mem_ready still wins on it
  assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (instr_valid) w_next = ST_DECODE;
      ST_DECODE: w_next = w_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC:   w_next = ((r_cls == CLS_L) || (r_cls == CLS_S)) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready)      w_next = ST_WB;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_WB:     w_next = ST_IDLE;
      ST_TRAP:   if (trap_ack) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Instruction register: captured only on the IDLE handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_ir <= '0;
    else if ((r_state == ST_IDLE) && instr_valid) r_ir <= instr;
  end

  // Class register: snapshot of the decoder result taken in DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cls <= CLS_NONE;
    else if (r_state == ST_DECODE) r_cls <= w_cls;
  end

  // MEM cycle counter: counts while waiting, zero whenever MEM is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                r_cnt <= '0;
    else if ((r_state == ST_MEM) && !mem_ready && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
    else                                                    r_cnt <= '0;
  end

  // Trap cause: set on entry to TRAP, held until acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_DECODE: if (w_illegal) r_cause <= CAUSE_ILLEGAL;
        ST_MEM:    if (!mem_ready && w_timeout) r_cause <= CAUSE_TIMEOUT;
        ST_TRAP:   if (trap_ack) r_cause <= CAUSE_NONE;
        default:   ;
      endcase
    end
  end

  assign w_dp_valid = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

  // Output decode from state, class and IR; everything defaults low
  always_comb begin
    instr_ready = (r_state == ST_IDLE);
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_req     = 1'b0;
    store       = 1'b0;
    op_b        = 1'b0;
    pc_write    = 1'b0;
    trap        = 1'b0;
    op_a        = OPA_RS1;
    imm_sel     = IMM_I;
    next_pc     = NPC_SEQ;
    alu_op      = ALU_ADD;
    trap_cause  = CAUSE_NONE;

    // Datapath selects stay stable from EXEC through WB
    if (w_dp_valid) begin
      case (r_cls)
        CLS_R: alu_op = {r_ir[30], r_ir[14:12]};
        CLS_I: begin
          op_b   = 1'b1;
          // Only shift-right uses funct7[5] (SRLI vs SRAI); elsewhere bit 30 is immediate
          alu_op = (r_ir[14:12] == 3'b101) ? {r_ir[30], r_ir[14:12]} : {1'b0, r_ir[14:12]};
        end
        CLS_L: op_b = 1'b1;
        CLS_S: begin
          op_b    = 1'b1;
          imm_sel = IMM_S;
        end
        CLS_B: begin
          imm_sel = IMM_B;
          alu_op  = ALU_SUB;
        end
        CLS_JAL: begin
          op_a    = OPA_PC;
          op_b    = 1'b1;
          imm_sel = IMM_J;
        end
        CLS_JALR: begin
          op_a = OPA_PC;
          op_b = 1'b1;
        end
        CLS_LUI: begin
          op_a    = OPA_ZERO;
          op_b    = 1'b1;
          imm_sel = IMM_U;
        end
        CLS_AUIPC: begin
          op_a    = OPA_PC;
          op_b    = 1'b1;
          imm_sel = IMM_U;
        end
        default: ;
      endcase
    end

    case (r_state)
      ST_MEM: begin
        mem_req = 1'b1;
        store   = (r_cls == CLS_S);
      end
      ST_WB: begin
        pc_write   = 1'b1;
        reg_write  = cls_writes_rd(r_cls);
        mem_to_reg = (r_cls == CLS_L);
        case (r_cls)
          CLS_JAL:  next_pc = NPC_JAL;
          CLS_JALR: next_pc = NPC_JALR;
          CLS_B:    next_pc = branch_taken ? NPC_BR : NPC_SEQ;
          default:  next_pc = NPC_SEQ;
        endcase
      end
      ST_TRAP: begin
        trap       = 1'b1;
        trap_cause = r_cause;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class,
// memory wait/timeout paths, traps and mid-instruction reset.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        trap_ack = 1'b0;
  logic        reg_write, mem_to_reg, mem_req, store, op_b, pc_write, trap;
  logic [1:0]  op_a, next_pc, trap_cause;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_op;

  int nvec = 0;
  int nerr = 0;

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .trap_ack(trap_ack), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .mem_req(mem_req), .store(store), .op_b(op_b), .pc_write(pc_write),
    .trap(trap), .op_a(op_a), .imm_sel(imm_sel), .next_pc(next_pc),
    .alu_op(alu_op), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // {reg_write, mem_to_reg, op_b, op_a, imm_sel, next_pc, alu_op}
  wire [13:0] wb_vec  = {reg_write, mem_to_reg, op_b, op_a, imm_sel, next_pc, alu_op};
  // every output except instr_ready
  wire [19:0] all_out = {reg_write, mem_to_reg, mem_req, store, op_b, pc_write, trap,
                         op_a, imm_sel, next_pc, alu_op, trap_cause};
  localparam logic [13:0] EXEC_MASK = 14'b0_0_1_11_111_00_1111;

  typedef struct packed {
    logic [31:0] ins;
    logic        br;
    logic [13:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one instruction from IDLE; returns with the FSM in DECODE
  task automatic send(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nvec++; if (instr_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    nvec++; if (all_out !== 20'h0) begin nerr++; $display("FAIL reset_outs got=%h exp=0", all_out); end
    instr = 32'h002081B3; instr_valid = 1'b1;
    tick();
    nvec++; if (instr_ready !== 1'b1 || all_out !== 20'h0) begin
      nerr++; $display("FAIL reset_hold ready=%b outs=%h exp ready=1 outs=0", instr_ready, all_out);
    end
    instr_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nonmem();
    vec_t tbl[10];
    tbl[0] = '{32'h002081B3, 1'b0, {1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,4'b0000}}; // ADD
    tbl[1] = '{32'h40208133, 1'b0, {1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,4'b1000}}; // SUB
    tbl[2] = '{32'h40315093, 1'b0, {1'b1,1'b0,1'b1,2'b00,3'b000,2'b00,4'b1101}}; // SRAI
    tbl[3] = '{32'h40004093, 1'b0, {1'b1,1'b0,1'b1,2'b00,3'b000,2'b00,4'b0100}}; // XORI imm bit30
    tbl[4] = '{32'h00208463, 1'b1, {1'b0,1'b0,1'b0,2'b00,3'b010,2'b10,4'b1000}}; // BEQ taken
    tbl[5] = '{32'h00208463, 1'b0, {1'b0,1'b0,1'b0,2'b00,3'b010,2'b00,4'b1000}}; // BEQ not taken
    tbl[6] = '{32'h008000EF, 1'b0, {1'b1,1'b0,1'b1,2'b10,3'b100,2'b01,4'b0000}}; // JAL
    tbl[7] = '{32'h000080E7, 1'b0, {1'b1,1'b0,1'b1,2'b10,3'b000,2'b11,4'b0000}}; // JALR
    tbl[8] = '{32'h000010B7, 1'b0, {1'b1,1'b0,1'b1,2'b11,3'b011,2'b00,4'b0000}}; // LUI
    tbl[9] = '{32'h00001097, 1'b0, {1'b1,1'b0,1'b1,2'b10,3'b011,2'b00,4'b0000}}; // AUIPC
    for (int i = 0; i < 10; i++) begin
      branch_taken = tbl[i].br;
      send(tbl[i].ins);
      nvec++; if (all_out !== 20'h0 || instr_ready !== 1'b0) begin
        nerr++; $display("FAIL decode_quiet[%0d] outs=%h ready=%b exp 0/0", i, all_out, instr_ready);
      end
      tick();
      nvec++; if ((wb_vec & EXEC_MASK) !== (tbl[i].exp & EXEC_MASK) || pc_write !== 1'b0) begin
        nerr++; $display("FAIL exec_sel[%0d] got=%b pcw=%b exp=%b", i, wb_vec, pc_write, tbl[i].exp & EXEC_MASK);
      end
      tick();
      nvec++; if (wb_vec !== tbl[i].exp) begin
        nerr++; $display("FAIL wb_vec[%0d] got=%b exp=%b", i, wb_vec, tbl[i].exp);
      end
      nvec++; if (pc_write !== 1'b1 || mem_req !== 1'b0 || trap !== 1'b0 || instr_ready !== 1'b0) begin
        nerr++; $display("FAIL wb_strobes[%0d] pcw=%b mreq=%b trap=%b rdy=%b exp 1/0/0/0", i, pc_write, mem_req, trap, instr_ready);
      end
      tick();
      nvec++; if (instr_ready !== 1'b1 || all_out !== 20'h0) begin
        nerr++; $display("FAIL back_idle[%0d] rdy=%b outs=%h exp 1/0", i, instr_ready, all_out);
      end
    end
    branch_taken = 1'b0;
  endtask

  // Load/store through MEM, mem_ready raised on MEM cycle n_ready (0 = never)
  task automatic test_load(input int n_ready);
    send(32'h0000A183);
    tick(); // EXEC
    tick(); // MEM cycle 1
    for (int k = 1; k <= n_ready; k++) begin
      nvec++; if (mem_req !== 1'b1 || store !== 1'b0 || pc_write !== 1'b0 || op_b !== 1'b1) begin
        nerr++; $display("FAIL lw_mem[%0d] mreq=%b st=%b pcw=%b opb=%b exp 1/0/0/1", k, mem_req, store, pc_write, op_b);
      end
      if (k == n_ready) mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
    end
    nvec++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || pc_write !== 1'b1 || mem_req !== 1'b0 || trap !== 1'b0) begin
      nerr++; $display("FAIL lw_wb n=%0d rw=%b m2r=%b pcw=%b mreq=%b trap=%b exp 1/1/1/0/0", n_ready, reg_write, mem_to_reg, pc_write, mem_req, trap);
    end
    tick();
    nvec++; if (instr_ready !== 1'b1) begin nerr++; $display("FAIL lw_idle got=%b exp=1", instr_ready); end
  endtask

  task automatic test_timeout();
    send(32'h0020A023);
    tick();
    tick();
    for (int k = 1; k <= 16; k++) begin
      nvec++; if (mem_req !== 1'b1 || store !== 1'b1 || imm_sel !== 3'b001 || trap !== 1'b0) begin
        nerr++; $display("FAIL sw_mem[%0d] mreq=%b st=%b imm=%b trap=%b exp 1/1/001/0", k, mem_req, store, imm_sel, trap);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      nvec++; if (trap !== 1'b1 || trap_cause !== 2'b10 || pc_write !== 1'b0 || reg_write !== 1'b0 || mem_req !== 1'b0) begin
        nerr++; $display("FAIL sw_trap[%0d] trap=%b cause=%b pcw=%b rw=%b mreq=%b exp 1/10/0/0/0", k, trap, trap_cause, pc_write, reg_write, mem_req);
      end
      tick();
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    nvec++; if (instr_ready !== 1'b1 || all_out !== 20'h0) begin
      nerr++; $display("FAIL sw_ack rdy=%b outs=%h exp 1/0", instr_ready, all_out);
    end
  endtask

  task automatic test_illegal();
    send(32'h0000007F);
    tick();
    nvec++; if (trap !== 1'b1 || trap_cause !== 2'b01 || pc_write !== 1'b0 || op_b !== 1'b0) begin
      nerr++; $display("FAIL ill_trap trap=%b cause=%b pcw=%b opb=%b exp 1/01/0/0", trap, trap_cause, pc_write, op_b);
    end
    tick();
    nvec++; if (trap !== 1'b1 || pc_write !== 1'b0 || instr_ready !== 1'b0) begin
      nerr++; $display("FAIL ill_hold trap=%b pcw=%b rdy=%b exp 1/0/0", trap, pc_write, instr_ready);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    nvec++; if (instr_ready !== 1'b1 || trap_cause !== 2'b00) begin
      nerr++; $display("FAIL ill_ack rdy=%b cause=%b exp 1/00", instr_ready, trap_cause);
    end
  endtask

  task automatic test_reset_mid();
    // reset while waiting in MEM
    send(32'h0000A183);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    nvec++; if (instr_ready !== 1'b1 || all_out !== 20'h0) begin
      nerr++; $display("FAIL rst_mem rdy=%b outs=%h exp 1/0", instr_ready, all_out);
    end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      nvec++; if (pc_write !== 1'b0 || reg_write !== 1'b0 || instr_ready !== 1'b1) begin
        nerr++; $display("FAIL rst_mem_after[%0d] pcw=%b rw=%b rdy=%b exp 0/0/1", k, pc_write, reg_write, instr_ready);
      end
    end
    mem_ready = 1'b0;
    // reset while in TRAP clears the cause
    send(32'h0000007F);
    tick();
    #2 rst = 1'b1;
    #1;
    nvec++; if (trap !== 1'b0 || trap_cause !== 2'b00 || instr_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_trap trap=%b cause=%b rdy=%b exp 0/00/1", trap, trap_cause, instr_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      nvec++; if (pc_write !== ((i == 3) || (i == 7))) begin
        nerr++; $display("FAIL b2b_pcw[%0d] got=%b exp=%b", i, pc_write, (i == 3) || (i == 7));
      end
    end
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load(3);
    test_load(1);
    test_load(16);
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of MEM cycles to wait for mem_ready; legal range 2..255.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(MEM_TIMEOUT+1), meaning the timeout counter width (derived, not overridden).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 instr  input  32  the instruction word, sampled when instr_valid and instr_ready are both high.
REQ-006 instr_valid / instr_ready  input / output  1 / 1  the instruction handshake.
REQ-007 branch_taken  input  1  the comparison result from the branch unit, sampled in WB.
REQ-008 mem_ready  input  1  data-memory completion, sampled in MEM.
REQ-009 trap_ack  input  1  acknowledges and clears a trap.
REQ-010 reg_write, mem_to_reg, mem_req, store, op_b, pc_write, trap  output  1 each  control strobes.
REQ-011 op_a  output  2  operand A select: 00 rs1, 10 PC, 11 zero.
REQ-012 imm_sel  output  3  immediate select: I 000, S 001, B 010, U 011, J 100.
REQ-013 next_pc  output  2  PC source: 00 PC+4, 01 JAL target, 10 branch target, 11 JALR target.
REQ-014 alu_op  output  4  ALU operation code {funct7[5], funct3}; ADD is 0000 and SUB is 1000.
REQ-015 trap_cause  output  2  trap reason: 01 illegal opcode, 10 memory timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, DECODE, EXEC, MEM, WB and TRAP.
REQ-017 IDLE: instr_ready=1; on handshake, latch instr into IR and go to DECODE; otherwise stay in IDLE.
REQ-018 instr_ready SHALL be 0 in every state except IDLE, so one instruction is in flight at most.
REQ-019 DECODE: classify IR[6:0] into R/I/L/S/B/JAL/JALR/LUI/AUIPC (standard RV32I opcodes) and register the class; an unknown opcode goes to TRAP with cause 01; otherwise go to EXEC.
REQ-020 EXEC: the L or S class goes to MEM; all other classes go to WB; EXEC lasts one cycle.
REQ-021 MEM: mem_req=1 and store=(class==S); the timeout counter increments each cycle.
REQ-022 In MEM, mem_ready=1 goes to WB and clears the counter.
REQ-023 In MEM, a counter reaching MEM_TIMEOUT without mem_ready goes to TRAP with cause 10.
REQ-024 In MEM, mem_ready arriving on the same cycle as the timeout SHALL win and go to WB.
REQ-025 WB: pc_write=1 for one cycle, then go to IDLE.
REQ-026 In WB, reg_write=1 for R, I, L, JAL, JALR, LUI and AUIPC; mem_to_reg=1 for L only.
REQ-027 In WB, next_pc=01 for JAL, 11 for JALR, 10 for B when branch_taken=1, and 00 otherwise.
REQ-028 op_a, op_b, imm_sel and alu_op SHALL be valid from EXEC through WB and 0 in IDLE, DECODE and TRAP.
REQ-029 op_a=10 for JAL, JALR and AUIPC; 11 for LUI; 00 otherwise.
REQ-030 op_b=0 (rs2) for R and B; 1 (immediate) otherwise.
REQ-031 alu_op SHALL be {IR[30], IR[14:12]} for R, and for I with funct3=101.
REQ-032 alu_op SHALL be {0, IR[14:12]} for other I.
REQ-033 alu_op SHALL be 1000 for B and 0000 for L, S, JAL, JALR, LUI and AUIPC.
REQ-034 TRAP: trap=1 and trap_cause is held; pc_write=0 and reg_write=0.
REQ-035 TRAP: trap_ack=1 goes to IDLE and clears trap_cause.
REQ-036 Every strobe not asserted by the current state SHALL be 0.
REQ-037 Instruction latency, handshake to the end of WB: 4 cycles for non-memory classes; 4+n cycles for L/S, where n is the number of MEM cycles (n ≥ 1).

Reset
REQ-038 While rst=1, the FSM SHALL be in IDLE, IR=0, the class register=none, the timeout counter=0 and trap_cause=00.
REQ-039 While rst=1, every output SHALL be 0 except instr_ready=1.
REQ-040 Reset asserted mid-instruction (including in MEM or TRAP) SHALL abandon the instruction immediately; no pc_write or reg_write follows.

Structure
REQ-041 Package ctrl_pkg SHALL hold the state enum, the opcode constants, the class enum, and the op_a, imm_sel, next_pc, alu_op and trap_cause encodings.
REQ-042 Opcode classification SHALL live in one combinational sub-module, rv32_opcode_class (IR[6:0] in, class/illegal out); the FSM, counter and output decode SHALL live in multicycle_control.

Verification
REQ-043 ADD x3,x1,x2 (0x002081B3) handshake -> exactly 4 cycles later WB with reg_write=1, op_b=0, alu_op=0000, next_pc=00, pc_write=1.
REQ-044 LW (0x0000A183), mem_ready after 3 MEM cycles -> MEM held 3 cycles with mem_req=1 and store=0, then WB with mem_to_reg=1 and reg_write=1.
REQ-045 SW (0x0020A023), mem_ready never asserted, MEM_TIMEOUT=16 -> TRAP after 16 MEM cycles with cause 10; trap_ack -> IDLE with instr_ready=1.
REQ-046 BEQ (0x00208463) with branch_taken=1 -> WB with next_pc=10, reg_write=0, alu_op=1000; with branch_taken=0 -> next_pc=00.
REQ-047 Opcode 0x7F -> TRAP with cause 01 and no pc_write; rst asserted in MEM -> all outputs 0 and instr_ready=1 asynchronously.
